// File: rtl/sbox_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_share_arb
//  Description : Round-robin scheduler sharing one composite-field AES S-box
//                among N_REQ byte requesters. Two-stage pipeline: grant ->
//                stage-1 register -> S-box -> per-requester response slot.
//  Revision    : 1.0  initial release
// ============================================================================
module sbox_share_arb #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [8*N_REQ-1:0]   rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic                 busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // GF(2^4) with x^4 + x + 1; composite GF((2^4)^2) with y^2 + y + LAMBDA
    localparam logic [3:0] C_LAMBDA = 4'hC;

    // ---------------- GF(2^4) building blocks -------------------------------
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        p = '0;
        for (int i = 3; i >= 0; i--) begin
            p = {p[2:0], 1'b0} ^ (p[3] ? 4'h3 : 4'h0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[1], q[2], q[2] ^ q[0]};
    endfunction

    // q^-1 = q^14 = q^2 * q^4 * q^8 (maps 0 to 0, as the S-box needs)
    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic [3:0] s2, s4, s8;
        s2 = gf4_sq(q);
        s4 = gf4_sq(s2);
        s8 = gf4_sq(s4);
        return gf4_mul(gf4_mul(s2, s4), s8);
    endfunction

    // ---------------- basis-change helpers ----------------------------------
    // AES polynomial-basis multiply (x^8+x^4+x^3+x+1); elaboration time only
    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 7; i >= 0; i--) begin
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    // Linear map over GF(2): XOR of the columns selected by the set bits of x
    function automatic logic [7:0] lin_map(input logic [7:0] x, input logic [63:0] cols);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) y = y ^ cols[8*i +: 8];
        end
        return y;
    endfunction

    // Composite -> AES isomorphism: find roots X of x^4+x+1 and Y of
    // y^2+y+LAMBDA(X) inside the AES field; basis images are X^j and Y*X^j.
    function automatic logic [63:0] f_phi_cols();
        logic [7:0] xr, yr, x2, x3, lam, c;
        logic       found;
        xr    = 8'h02;
        found = 1'b0;
        for (int v = 2; v < 256; v++) begin
            c = 8'(v);
            if (!found && ((gf8_mul(gf8_mul(c, c), gf8_mul(c, c)) ^ c ^ 8'h01) == 8'h00)) begin
                xr    = c;
                found = 1'b1;
            end
        end
        x2    = gf8_mul(xr, xr);
        x3    = gf8_mul(x2, xr);
        lam   = x3 ^ x2;
        yr    = 8'h02;
        found = 1'b0;
        for (int v = 2; v < 256; v++) begin
            c = 8'(v);
            if (!found && ((gf8_mul(c, c) ^ c ^ lam) == 8'h00)) begin
                yr    = c;
                found = 1'b1;
            end
        end
        return {gf8_mul(yr, x3), gf8_mul(yr, x2), gf8_mul(yr, xr), yr,
                x3, x2, xr, 8'h01};
    endfunction

    // AES -> composite map: preimage of each AES basis vector under phi
    function automatic logic [63:0] f_delta_cols(input logic [63:0] phi);
        logic [63:0] d;
        logic        found;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            found = 1'b0;
            for (int v = 0; v < 256; v++) begin
                if (!found && (lin_map(8'(v), phi) == (8'h01 << i))) begin
                    d[8*i +: 8] = 8'(v);
                    found       = 1'b1;
                end
            end
        end
        return d;
    endfunction

    localparam logic [63:0] C_PHI_COLS   = f_phi_cols();
    localparam logic [63:0] C_DELTA_COLS = f_delta_cols(C_PHI_COLS);

    // ---------------- state -------------------------------------------------
    logic [PW-1:0]      r_ptr;
    logic [N_REQ-1:0]   r_pend;
    logic               r_s1_v;
    logic [PW-1:0]      r_s1_id;
    logic [7:0]         r_s1_byte;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [8*N_REQ-1:0] r_rsp_data;

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_grant;
    logic [PW-1:0]      w_gnt_id;
    logic [PW-1:0]      w_idx;
    logic               w_gnt_any;
    logic               w_take;
    logic [N_REQ-1:0]   w_s1_onehot;
    logic [7:0]         w_comp;
    logic [3:0]         w_d;
    logic [3:0]         w_dinv;
    logic [7:0]         w_inv_comp;
    logic [7:0]         w_inv;
    logic [7:0]         w_sbox;

    // Round-robin search over eligible requesters starting at r_ptr
    always_comb begin
        w_elig    = req_valid & ~r_pend;
        w_grant   = '0;
        w_gnt_id  = '0;
        w_gnt_any = 1'b0;
        w_idx     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_idx = PW'((int'(r_ptr) + off) % N_REQ);
            if (!w_gnt_any && w_elig[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_gnt_id       = w_idx;
                w_gnt_any      = 1'b1;
            end
        end
        w_take    = rst_n & w_gnt_any;
        req_ready = rst_n ? w_grant : '0;
    end

    // Shared S-box: inversion in the composite field, then the AES affine map
    always_comb begin
        w_comp     = lin_map(r_s1_byte, C_DELTA_COLS);
        w_d        = gf4_mul(gf4_sq(w_comp[7:4]), C_LAMBDA)
                   ^ gf4_mul(w_comp[7:4] ^ w_comp[3:0], w_comp[3:0]);
        w_dinv     = gf4_inv(w_d);
        w_inv_comp = {gf4_mul(w_comp[7:4], w_dinv),
                      gf4_mul(w_comp[7:4] ^ w_comp[3:0], w_dinv)};
        w_inv      = lin_map(w_inv_comp, C_PHI_COLS);
        w_sbox     = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                   ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
        w_s1_onehot = r_s1_v ? (N_REQ'(1) << r_s1_id) : '0;
    end

    // Pointer advance and stage-1 capture of the granted byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_s1_v    <= 1'b0;
            r_s1_id   <= '0;
            r_s1_byte <= '0;
        end else begin
            r_s1_v <= w_take;
            if (w_take) begin
                r_ptr     <= (w_gnt_id == PW'(N_REQ - 1)) ? '0 : w_gnt_id + PW'(1);
                r_s1_id   <= w_gnt_id;
                r_s1_byte <= req_data[8*w_gnt_id +: 8];
            end
        end
    end

    // Outstanding flags and response slots; a slot written here is always empty
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_pend      <= (r_pend | (w_take ? w_grant : '0)) & ~(r_rsp_valid & rsp_ready);
            r_rsp_valid <= (r_rsp_valid & ~rsp_ready) | w_s1_onehot;
            if (r_s1_v) begin
                r_rsp_data[8*r_s1_id +: 8] <= w_sbox;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_s1_v | (|r_pend);

endmodule
`default_nettype wire

// File: tb/tb_sbox_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sbox_share_arb
//  Description : Directed self-checking bench for sbox_share_arb (N_REQ = 4)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sbox_share_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    sbox_share_arb #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 4'hF;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_data  = 32'hA5A5_5A5A;
        rsp_ready = 4'hF;
        step();
        step();
        settle();
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000);
        end
        n_tests++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b expected %b", rsp_valid, 4'b0000);
        end
        n_tests++;
        if (rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h expected %h", rsp_data, 32'h0);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        step();
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0001;
        req_data  = 32'h0;
        settle();
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected %b", req_ready, 4'b0001);
        end
        step();
        req_valid = '0;
        settle();
        n_tests++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_cycle1: rsp_valid=%b busy=%b expected 0000 1", rsp_valid, busy);
        end
        step();
        settle();
        n_tests++;
        if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'h63) begin
            n_fail++;
            $display("FAIL single_rsp: rsp_valid=%b data=%h expected 0001 63", rsp_valid, rsp_data[7:0]);
        end
        step();
        settle();
        n_tests++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: rsp_valid=%b busy=%b expected 0000 0", rsp_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_s [4];
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        exp_s = '{8'h63, 8'h7C, 8'hED, 8'h16};
        apply_reset();
        req_valid = 4'hF;
        req_data  = {8'hFF, 8'h53, 8'h01, 8'h00};
        for (int t = 0; t < 7; t++) begin
            exp_rdy = (t < 4) ? 4'(1 << t) : 4'b0000;
            exp_rv  = (t >= 2 && t < 6) ? 4'(1 << (t - 2)) : 4'b0000;
            settle();
            n_tests++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL contention_grant t=%0d: got %b expected %b", t, req_ready, exp_rdy);
            end
            n_tests++;
            if (rsp_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL contention_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, exp_rv);
            end
            if (t >= 2 && t < 6) begin
                n_tests++;
                if (rsp_data[8*(t-2) +: 8] !== exp_s[t-2]) begin
                    n_fail++;
                    $display("FAIL contention_rsp_data t=%0d: got %h expected %h",
                             t, rsp_data[8*(t-2) +: 8], exp_s[t-2]);
                end
            end
            step();
            if (t < 4) req_valid[t] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        logic [7:0] q0 [4];
        logic [7:0] s0 [4];
        logic [7:0] q2 [4];
        logic [7:0] s2 [4];
        logic [3:0] exp_rdy;
        logic [3:0] exp_rv;
        int g0, g2, r0, r2;
        q0 = '{8'h00, 8'h01, 8'h02, 8'h03};
        s0 = '{8'h63, 8'h7C, 8'h77, 8'h7B};
        q2 = '{8'h10, 8'h11, 8'h20, 8'h80};
        s2 = '{8'hCA, 8'h82, 8'hB7, 8'hCD};
        g0 = 0; g2 = 0; r0 = 0; r2 = 0;
        apply_reset();
        req_valid = 4'b0101;
        for (int t = 0; t < 12; t++) begin
            req_data[7:0]   = q0[(g0 < 4) ? g0 : 3];
            req_data[23:16] = q2[(g2 < 4) ? g2 : 3];
            exp_rdy = (t % 3 == 0) ? 4'b0001 : (t % 3 == 1) ? 4'b0100 : 4'b0000;
            exp_rv  = (t % 3 == 2) ? 4'b0001 : (t % 3 == 0 && t >= 3) ? 4'b0100 : 4'b0000;
            settle();
            n_tests++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL fairness_grant t=%0d: got %b expected %b", t, req_ready, exp_rdy);
            end
            n_tests++;
            if (rsp_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL fairness_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, exp_rv);
            end
            if (exp_rv[0]) begin
                n_tests++;
                if (rsp_data[7:0] !== s0[r0]) begin
                    n_fail++;
                    $display("FAIL fairness_data0 t=%0d: got %h expected %h", t, rsp_data[7:0], s0[r0]);
                end
                r0++;
            end
            if (exp_rv[2]) begin
                n_tests++;
                if (rsp_data[23:16] !== s2[r2]) begin
                    n_fail++;
                    $display("FAIL fairness_data2 t=%0d: got %h expected %h", t, rsp_data[23:16], s2[r2]);
                end
                r2++;
            end
            if (exp_rdy[0]) g0++;
            if (exp_rdy[2]) g2++;
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy [10];
        exp_rdy = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b1000,
                    4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
        apply_reset();
        rsp_ready = 4'b1101;
        req_valid = 4'b1010;
        req_data  = {8'h53, 8'h00, 8'h01, 8'h00};
        for (int t = 0; t < 10; t++) begin
            if (t == 8) rsp_ready = 4'hF;
            settle();
            n_tests++;
            if (req_ready !== exp_rdy[t]) begin
                n_fail++;
                $display("FAIL backpressure_grant t=%0d: got %b expected %b", t, req_ready, exp_rdy[t]);
            end
            if (t >= 2 && t <= 8) begin
                n_tests++;
                if (rsp_valid[1] !== 1'b1 || rsp_data[15:8] !== 8'h7C) begin
                    n_fail++;
                    $display("FAIL backpressure_hold t=%0d: valid=%b data=%h expected 1 7c",
                             t, rsp_valid[1], rsp_data[15:8]);
                end
            end
            if (t == 9) begin
                n_tests++;
                if (rsp_valid[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL backpressure_release: valid=%b expected 0", rsp_valid[1]);
                end
            end
            step();
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        req_valid = 4'b1000;
        req_data  = {8'h53, 24'h0};
        settle();
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL midflight_grant: got %b expected %b", req_ready, 4'b1000);
        end
        step();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        settle();
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL midflight_ready_in_reset: got %b expected %b", req_ready, 4'b0000);
        end
        step();
        rst_n     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_tests++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midflight_discard i=%0d: rsp_valid=%b busy=%b expected 0000 0",
                         i, rsp_valid, busy);
            end
            step();
        end
        req_valid = 4'b0110;
        settle();
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL midflight_first_grant: got %b expected %b", req_ready, 4'b0010);
        end
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        settle();
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL midflight_ptr_cleared: got %b expected %b", req_ready, 4'b0001);
        end
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_wrap();
        apply_reset();
        req_valid = 4'b0100;
        req_data  = 32'h0;
        settle();
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_grant2: got %b expected %b", req_ready, 4'b0100);
        end
        step();
        req_valid = 4'b1001;
        settle();
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_grant3: got %b expected %b", req_ready, 4'b1000);
        end
        step();
        req_valid = 4'b0001;
        settle();
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant0: got %b expected %b", req_ready, 4'b0001);
        end
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
        settle();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle_busy: got %b expected %b", busy, 1'b0);
        end
        req_valid = 4'hF;
        settle();
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_ptr_is_1: got %b expected %b", req_ready, 4'b0010);
        end
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 4'hF;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
